sp_ram_banked_arb: RTL and testbench
====================================

# sp_ram_banked_arb

Two-port, multi-bank scratchpad RAM with byte enables and a per-bank round-robin arbiter. It replaces the single-port byte-enable RAM in the SoC memory subsystem. Instruction fetch and data access (core or debug) can reach one shared memory concurrently. Both hit in the same cycle whenever they target different banks.

## Interface
- `ADDR_WIDTH`, 12: byte-address width; word-aligned.
- `DATA_WIDTH`, 32: word width; multiple of 8.
- `NUM_BANKS`, 2: power of two, ≥ 2; word-interleaved.
- `NUM_WORDS`, derived: `2**(ADDR_WIDTH-$clog2(DATA_WIDTH/8))`, total words; each bank holds `NUM_WORDS/NUM_BANKS`.
- `clk`  in  1  clock; everything on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `pN_req_i`  in  1  request from port N (N = 0, 1).
- `pN_gnt_o`  out  1  grant; combinational, same cycle as the request.
- `pN_addr_i`  in  ADDR_WIDTH  byte address; low `$clog2(DATA_WIDTH/8)` bits ignored.
- `pN_we_i`  in  1  1 = write, 0 = read.
- `pN_be_i`  in  DATA_WIDTH/8  byte enables; write only.
- `pN_wdata_i`  in  DATA_WIDTH  write data; byte k = bits [8k+7:8k].
- `pN_rvalid_o`  out  1  response; one cycle after grant.
- `pN_rdata_o`  out  DATA_WIDTH  read data; valid while rvalid.
- `conflict_cnt_o`  out  16  saturating count of bank-conflict cycles.

## Operation
- Address split:
  - word = `addr[ADDR_WIDTH-1:$clog2(DATA_WIDTH/8)]`.
  - bank = `word[$clog2(NUM_BANKS)-1:0]`.
  - row = remaining upper bits.
- Different banks, or only one port requesting: each requester is granted.
- Same bank, both requesting: a conflict. Only the port holding priority is granted.
  - Priority is a single flop `prio`, reset to port 0.
  - After a conflict cycle, `prio` moves to the losing port.
  - Non-conflict cycles leave `prio` unchanged.
- Requester protocol: an ungranted port keeps req and all fields stable until granted. The bench checks this; the RTL does not.
- No combinational path from gnt to req. gnt depends only on req, addr and `prio`.
- Granted write:
  - Bytes with `be[k]=1` are updated at the next edge; other bytes are unchanged.
  - `be=0` is a legal no-op write.
- Granted read or write: the bank reads the addressed row in the same cycle. rdata returns the contents **before** that cycle's write (read-before-write).
- Per port, a registered bank-select steers the correct bank output to `pN_rdata_o`.
- Between responses, rdata holds its last value.
- `conflict_cnt_o`:
  - +1 per conflict cycle.
  - Saturates at 0xFFFF.
  - Cleared only by reset.
- Memory contents are not reset; power-up contents are X.

## Timing
- Latency: grant in cycle T gives rvalid and rdata in cycle T+1. Throughput is one access per port per cycle.
- Back-to-back grants produce back-to-back rvalid pulses in order.
- Write then read of the same word by the other port in the next cycle returns the new data.
- Same-cycle access to the same word by both ports cannot happen, because it is always a conflict.
- Reset values:
  - `pN_rvalid_o` = 0.
  - `pN_rdata_o` = 0.
  - `conflict_cnt_o` = 0.
  - `prio` = 0.
  - bank-select = 0.
- Reset asserted mid-access: rvalid clears asynchronously and the pending response is dropped. A write already clocked in stays in memory.

## Structure
- Package `sp_ram_banked_pkg`:
  - `PORTS = 2`.
  - Function `bank_of(addr)`.
  - `cnt_t = logic [15:0]`.
- Sub-module `ram_bank_be`: one bank, parameterised by depth and width.
  - Interface: en, we, row, be, wdata.
  - Registered rdata; read-before-write.
  - Instantiated `NUM_BANKS` times in a generate loop.
- Top level holds the grant logic, `prio`, the per-port response pipeline flops, the rdata muxes and the counter.

## Test plan
- Write/read, no conflict: p0 writes 0xDEADBEEF to 0x000 (bank 0) while p1 writes 0x12345678 to 0x004 (bank 1). Both are granted. Reads of both addresses then return those values with rvalid at T+1.
- Byte enables: write 0xFFFFFFFF to 0x010, then 0xAABBCCDD with `be=4'b0101`. A read returns 0xFFBBFFDD.
- Conflict round-robin: both ports read bank 0 for 4 consecutive cycles, holding req until granted. Grants alternate p0, p1, p0, p1 and `conflict_cnt_o` = 4.
- Read-before-write: p0 writes 0x11111111 to 0x020 (old value 0x0). The granted write returns rdata 0x0. The next read returns 0x11111111.
- Counter saturation: force more than 65535 conflict cycles. The counter stays at 0xFFFF.
- Reset mid-op: assert `rst_n` low in the cycle after a grant. rvalid is 0 immediately, `prio` is 0, the counter is 0, and previously written data survives.

Source files
------------

// File: rtl/sp_ram_banked_pkg.sv
// Shared types and helpers for the banked two-port scratchpad.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sp_ram_banked_pkg;

    localparam int PORTS = 2;

    typedef logic [15:0] cnt_t;

    // Bank index of a byte address: drop the byte offset, keep the low word bits.
    function automatic int unsigned bank_of(input logic [31:0] addr,
                                            input int unsigned off_bits,
                                            input int unsigned bank_bits);
        logic [31:0] word;
        word = addr >> off_bits;
        return word & ((32'd1 << bank_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/sp_ram_banked_arb_bank.sv
// Single RAM bank with byte-enable writes and a registered read port.
// Latency: rdata valid one cycle after en; returns contents from before a same-cycle write.
// Backpressure: none; accepts an access every cycle en is high.
//   clk   : clock
//   en    : access strobe (read, or read-before-write when we=1)
//   we    : write enable
//   row   : word index within the bank
//   be    : byte enables, write only
//   wdata : write data
//   rdata : registered read data, holds while en is low
module ram_bank_be #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] row,
    input  logic [WIDTH/8-1:0]       be,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[row];
            if (we) begin
                for (int k = 0; k < WIDTH / 8; k++) begin
                    if (be[k]) begin
                        mem[row][8*k +: 8] <= wdata[8*k +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/sp_ram_banked_arb.sv
// Two-port word-interleaved scratchpad with per-bank round-robin arbitration.
// Latency: grant is combinational in cycle T; rvalid/rdata in T+1; one access per port per cycle.
// Backpressure: a losing port sees gnt low and must hold req and fields until granted.
//   clk, rst_n            : clock, async active-low reset
//   pN_req_i / pN_gnt_o   : request / same-cycle grant
//   pN_addr_i, pN_we_i    : byte address, write select
//   pN_be_i, pN_wdata_i   : byte enables, write data
//   pN_rvalid_o/rdata_o   : response one cycle after grant; rdata holds between responses
//   conflict_cnt_o        : saturating count of same-bank conflict cycles
module sp_ram_banked_arb
    import sp_ram_banked_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BANKS  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    p0_req_i,
    output logic                    p0_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
    input  logic                    p0_we_i,
    input  logic [DATA_WIDTH/8-1:0] p0_be_i,
    input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
    output logic                    p0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p0_rdata_o,
    input  logic                    p1_req_i,
    output logic                    p1_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
    input  logic                    p1_we_i,
    input  logic [DATA_WIDTH/8-1:0] p1_be_i,
    input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
    output logic                    p1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p1_rdata_o,
    output cnt_t                    conflict_cnt_o
);

    localparam int BE_W      = DATA_WIDTH / 8;
    localparam int OFF_W     = $clog2(BE_W);
    localparam int WORD_W    = ADDR_WIDTH - OFF_W;
    localparam int NUM_WORDS = 2 ** WORD_W;
    localparam int BANK_W    = $clog2(NUM_BANKS);
    localparam int DEPTH     = NUM_WORDS / NUM_BANKS;
    localparam int ROW_W     = WORD_W - BANK_W;

    logic [PORTS-1:0]      req, gnt, we, rvalid_q;
    logic [ADDR_WIDTH-1:0] addr      [PORTS];
    logic [BE_W-1:0]       be        [PORTS];
    logic [DATA_WIDTH-1:0] wdata     [PORTS];
    logic [DATA_WIDTH-1:0] rdata_mux [PORTS];
    logic [DATA_WIDTH-1:0] hold_q    [PORTS];
    logic [BANK_W-1:0]     bank      [PORTS];
    logic [BANK_W-1:0]     sel_q     [PORTS];
    logic [ROW_W-1:0]      row       [PORTS];
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];

    logic prio_q;
    logic conflict;
    cnt_t cnt_q;

    assign req      = {p1_req_i, p0_req_i};
    assign we       = {p1_we_i, p0_we_i};
    assign addr[0]  = p0_addr_i;
    assign addr[1]  = p1_addr_i;
    assign be[0]    = p0_be_i;
    assign be[1]    = p1_be_i;
    assign wdata[0] = p0_wdata_i;
    assign wdata[1] = p1_wdata_i;

    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            bank[p]      = BANK_W'(bank_of(32'(addr[p]), OFF_W, BANK_W));
            row[p]       = addr[p][ADDR_WIDTH-1 -: ROW_W];
            rdata_mux[p] = bank_rdata[sel_q[p]];
        end
    end

    // Grant is a pure function of req, bank and prio; the loser of a conflict
    // sees gnt low and retries with the same fields.
    always_comb begin
        conflict = req[0] && req[1] && (bank[0] == bank[1]);
        gnt[0]   = req[0] && (!conflict || !prio_q);
        gnt[1]   = req[1] && (!conflict ||  prio_q);
    end

    // Both ports granted implies different banks, so each bank has at most one owner.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic                  use_p1;
        logic                  bank_en;
        logic                  bank_we;
        logic [ROW_W-1:0]      bank_row;
        logic [BE_W-1:0]       bank_be;
        logic [DATA_WIDTH-1:0] bank_wdata;

        always_comb begin
            use_p1     = gnt[1] && (bank[1] == BANK_W'(b));
            bank_en    = use_p1 || (gnt[0] && (bank[0] == BANK_W'(b)));
            bank_we    = use_p1 ? we[1]    : we[0];
            bank_row   = use_p1 ? row[1]   : row[0];
            bank_be    = use_p1 ? be[1]    : be[0];
            bank_wdata = use_p1 ? wdata[1] : wdata[0];
        end

        ram_bank_be #(
            .DEPTH (DEPTH),
            .WIDTH (DATA_WIDTH)
        ) u_bank (
            .clk   (clk),
            .en    (bank_en),
            .we    (bank_we),
            .row   (bank_row),
            .be    (bank_be),
            .wdata (bank_wdata),
            .rdata (bank_rdata[b])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= '0;
            prio_q   <= 1'b0;
            cnt_q    <= '0;
            for (int p = 0; p < PORTS; p++) begin
                sel_q[p]  <= '0;
                hold_q[p] <= '0;
            end
        end else begin
            rvalid_q <= gnt;
            if (conflict) begin
                // Priority passes to the port that just lost.
                prio_q <= ~prio_q;
                if (cnt_q != 16'hFFFF) begin
                    cnt_q <= cnt_q + 16'd1;
                end
            end
            for (int p = 0; p < PORTS; p++) begin
                if (gnt[p]) begin
                    sel_q[p] <= bank[p];
                end
                // The bank register may be reused by the other port, so keep
                // a private copy of the last response.
                if (rvalid_q[p]) begin
                    hold_q[p] <= rdata_mux[p];
                end
            end
        end
    end

    assign p0_gnt_o       = gnt[0];
    assign p1_gnt_o       = gnt[1];
    assign p0_rvalid_o    = rvalid_q[0];
    assign p1_rvalid_o    = rvalid_q[1];
    assign p0_rdata_o     = rvalid_q[0] ? rdata_mux[0] : hold_q[0];
    assign p1_rdata_o     = rvalid_q[1] ? rdata_mux[1] : hold_q[1];
    assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_sp_ram_banked_arb.sv
module tb_sp_ram_banked_arb;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          p0_req_i, p0_we_i, p1_req_i, p1_we_i;
    logic [AW-1:0] p0_addr_i, p1_addr_i;
    logic [BW-1:0] p0_be_i, p1_be_i;
    logic [DW-1:0] p0_wdata_i, p1_wdata_i;
    logic          p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o;
    logic [DW-1:0] p0_rdata_o, p1_rdata_o;
    logic [15:0]   conflict_cnt_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sp_ram_banked_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BANKS(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_i(p0_req_i), .p0_gnt_o(p0_gnt_o), .p0_addr_i(p0_addr_i), .p0_we_i(p0_we_i),
        .p0_be_i(p0_be_i), .p0_wdata_i(p0_wdata_i), .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o),
        .p1_req_i(p1_req_i), .p1_gnt_o(p1_gnt_o), .p1_addr_i(p1_addr_i), .p1_we_i(p1_we_i),
        .p1_be_i(p1_be_i), .p1_wdata_i(p1_wdata_i), .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
        .conflict_cnt_o(conflict_cnt_o)
    );

    task automatic set_p0(input logic req, input logic we, input logic [AW-1:0] addr,
                          input logic [BW-1:0] be, input logic [DW-1:0] wdata);
        p0_req_i = req; p0_we_i = we; p0_addr_i = addr; p0_be_i = be; p0_wdata_i = wdata;
    endtask

    task automatic set_p1(input logic req, input logic we, input logic [AW-1:0] addr,
                          input logic [BW-1:0] be, input logic [DW-1:0] wdata);
        p1_req_i = req; p1_we_i = we; p1_addr_i = addr; p1_be_i = be; p1_wdata_i = wdata;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_p0(0, 0, '0, '0, '0);
        set_p1(0, 0, '0, '0, '0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (p0_rvalid_o !== 1'b0) begin failures++; $display("FAIL reset_p0_rvalid actual=%0h required=0", p0_rvalid_o); end
        checks++; if (p1_rvalid_o !== 1'b0) begin failures++; $display("FAIL reset_p1_rvalid actual=%0h required=0", p1_rvalid_o); end
        checks++; if (p0_rdata_o !== 32'h0) begin failures++; $display("FAIL reset_p0_rdata actual=%08h required=00000000", p0_rdata_o); end
        checks++; if (p1_rdata_o !== 32'h0) begin failures++; $display("FAIL reset_p1_rdata actual=%08h required=00000000", p1_rdata_o); end
        checks++; if (conflict_cnt_o !== 16'h0) begin failures++; $display("FAIL reset_cnt actual=%04h required=0000", conflict_cnt_o); end
        checks++; if ({p1_gnt_o, p0_gnt_o} !== 2'b00) begin failures++; $display("FAIL reset_idle_gnt actual=%b required=00", {p1_gnt_o, p0_gnt_o}); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_no_conflict();
        set_p0(1, 1, 12'h000, 4'hF, 32'hDEADBEEF);
        set_p1(1, 1, 12'h004, 4'hF, 32'h12345678);
        @(negedge clk);
        checks++; if ({p1_gnt_o, p0_gnt_o} !== 2'b11) begin failures++; $display("FAIL nc_write_gnt actual=%b required=11", {p1_gnt_o, p0_gnt_o}); end
        step();
        checks++; if ({p1_rvalid_o, p0_rvalid_o} !== 2'b11) begin failures++; $display("FAIL nc_write_rvalid actual=%b required=11", {p1_rvalid_o, p0_rvalid_o}); end
        set_p0(1, 0, 12'h004, '0, '0);
        set_p1(1, 0, 12'h000, '0, '0);
        @(negedge clk);
        checks++; if ({p1_gnt_o, p0_gnt_o} !== 2'b11) begin failures++; $display("FAIL nc_read_gnt actual=%b required=11", {p1_gnt_o, p0_gnt_o}); end
        step();
        set_p0(0, 0, '0, '0, '0);
        set_p1(0, 0, '0, '0, '0);
        checks++; if ({p1_rvalid_o, p0_rvalid_o} !== 2'b11) begin failures++; $display("FAIL nc_read_rvalid actual=%b required=11", {p1_rvalid_o, p0_rvalid_o}); end
        checks++; if (p0_rdata_o !== 32'h12345678) begin failures++; $display("FAIL nc_p0_rdata actual=%08h required=12345678", p0_rdata_o); end
        checks++; if (p1_rdata_o !== 32'hDEADBEEF) begin failures++; $display("FAIL nc_p1_rdata actual=%08h required=deadbeef", p1_rdata_o); end
        checks++; if (conflict_cnt_o !== 16'h0) begin failures++; $display("FAIL nc_cnt actual=%04h required=0000", conflict_cnt_o); end
    endtask

    task automatic test_byte_en();
        set_p0(1, 1, 12'h010, 4'hF, 32'hFFFFFFFF);
        step();
        set_p0(1, 1, 12'h010, 4'b0101, 32'hAABBCCDD);
        step();
        checks++; if (p0_rdata_o !== 32'hFFFFFFFF) begin failures++; $display("FAIL be_rbw_rdata actual=%08h required=ffffffff", p0_rdata_o); end
        set_p0(0, 0, '0, '0, '0);
        set_p1(1, 0, 12'h010, '0, '0);
        step();
        checks++; if (p1_rvalid_o !== 1'b1 || p1_rdata_o !== 32'hFFBBFFDD) begin failures++; $display("FAIL be_merge actual=%b/%08h required=1/ffbbffdd", p1_rvalid_o, p1_rdata_o); end
        // be=0 is a no-op write
        set_p1(0, 0, '0, '0, '0);
        set_p0(1, 1, 12'h010, 4'h0, 32'h01234567);
        step();
        checks++; if (p0_rvalid_o !== 1'b1 || p0_rdata_o !== 32'hFFBBFFDD) begin failures++; $display("FAIL be_zero_resp actual=%b/%08h required=1/ffbbffdd", p0_rvalid_o, p0_rdata_o); end
        set_p0(0, 0, '0, '0, '0);
        set_p1(1, 0, 12'h010, '0, '0);
        step();
        set_p1(0, 0, '0, '0, '0);
        checks++; if (p1_rdata_o !== 32'hFFBBFFDD) begin failures++; $display("FAIL be_zero_noop actual=%08h required=ffbbffdd", p1_rdata_o); end
    endtask

    task automatic test_conflict_rr();
        logic e0;
        set_p0(1, 0, 12'h000, '0, '0);
        set_p1(1, 0, 12'h010, '0, '0);
        for (int i = 0; i < 4; i++) begin
            e0 = (i % 2 == 0);
            @(negedge clk);
            checks++; if ({p1_gnt_o, p0_gnt_o} !== {~e0, e0}) begin failures++; $display("FAIL rr_gnt[%0d] actual=%b required=%b", i, {p1_gnt_o, p0_gnt_o}, {~e0, e0}); end
            step();
            checks++; if ({p1_rvalid_o, p0_rvalid_o} !== {~e0, e0}) begin failures++; $display("FAIL rr_rvalid[%0d] actual=%b required=%b", i, {p1_rvalid_o, p0_rvalid_o}, {~e0, e0}); end
            if (e0) begin
                checks++; if (p0_rdata_o !== 32'hDEADBEEF) begin failures++; $display("FAIL rr_p0_rdata[%0d] actual=%08h required=deadbeef", i, p0_rdata_o); end
            end else begin
                checks++; if (p1_rdata_o !== 32'hFFBBFFDD) begin failures++; $display("FAIL rr_p1_rdata[%0d] actual=%08h required=ffbbffdd", i, p1_rdata_o); end
            end
        end
        set_p0(0, 0, '0, '0, '0);
        checks++; if (conflict_cnt_o !== 16'd4) begin failures++; $display("FAIL rr_cnt actual=%0d required=4", conflict_cnt_o); end
        // p1 alone on bank 0 is not a conflict, regardless of priority
        @(negedge clk);
        checks++; if ({p1_gnt_o, p0_gnt_o} !== 2'b10) begin failures++; $display("FAIL rr_single_gnt actual=%b required=10", {p1_gnt_o, p0_gnt_o}); end
        step();
        set_p1(0, 0, '0, '0, '0);
        checks++; if (conflict_cnt_o !== 16'd4) begin failures++; $display("FAIL rr_single_cnt actual=%0d required=4", conflict_cnt_o); end
    endtask

    task automatic test_rbw();
        set_p0(1, 1, 12'h020, 4'hF, 32'h0);
        step();
        set_p0(1, 1, 12'h020, 4'hF, 32'h11111111);
        step();
        checks++; if (p0_rvalid_o !== 1'b1 || p0_rdata_o !== 32'h0) begin failures++; $display("FAIL rbw_old actual=%b/%08h required=1/00000000", p0_rvalid_o, p0_rdata_o); end
        set_p0(0, 0, '0, '0, '0);
        set_p1(1, 0, 12'h020, '0, '0);
        step();
        set_p1(0, 0, '0, '0, '0);
        checks++; if (p1_rvalid_o !== 1'b1 || p1_rdata_o !== 32'h11111111) begin failures++; $display("FAIL rbw_new actual=%b/%08h required=1/11111111", p1_rvalid_o, p1_rdata_o); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a [3];
        logic [DW-1:0] d [3];
        a[0] = 12'h000; a[1] = 12'h004; a[2] = 12'h010;
        d[0] = 32'hDEADBEEF; d[1] = 32'h12345678; d[2] = 32'hFFBBFFDD;
        set_p0(1, 0, a[0], '0, '0);
        step();
        for (int i = 0; i < 3; i++) begin
            checks++; if (p0_rvalid_o !== 1'b1 || p0_rdata_o !== d[i]) begin failures++; $display("FAIL b2b[%0d] actual=%b/%08h required=1/%08h", i, p0_rvalid_o, p0_rdata_o, d[i]); end
            if (i < 2) begin
                set_p0(1, 0, a[i+1], '0, '0);
            end else begin
                set_p0(0, 0, '0, '0, '0);
                set_p1(1, 0, 12'h000, '0, '0);
            end
            step();
        end
        set_p1(0, 0, '0, '0, '0);
        // p1 just reused bank 0; p0 must still show its own last response
        checks++; if (p0_rvalid_o !== 1'b0 || p0_rdata_o !== 32'hFFBBFFDD) begin failures++; $display("FAIL b2b_hold actual=%b/%08h required=0/ffbbffdd", p0_rvalid_o, p0_rdata_o); end
    endtask

    task automatic test_reset_midop();
        set_p0(1, 1, 12'h040, 4'hF, 32'hCAFEF00D);
        step();
        set_p0(1, 0, 12'h000, '0, '0);
        set_p1(1, 0, 12'h040, '0, '0);
        @(negedge clk);
        checks++; if ({p1_gnt_o, p0_gnt_o} !== 2'b01) begin failures++; $display("FAIL rst_pre_gnt actual=%b required=01", {p1_gnt_o, p0_gnt_o}); end
        step();
        checks++; if (p0_rvalid_o !== 1'b1 || conflict_cnt_o !== 16'd5) begin failures++; $display("FAIL rst_pre_state actual=%b/%0d required=1/5", p0_rvalid_o, conflict_cnt_o); end
        rst_n = 1'b0;
        set_p0(0, 0, '0, '0, '0);
        set_p1(0, 0, '0, '0, '0);
        #1;
        checks++; if (p0_rvalid_o !== 1'b0 || p0_rdata_o !== 32'h0) begin failures++; $display("FAIL rst_async_resp actual=%b/%08h required=0/00000000", p0_rvalid_o, p0_rdata_o); end
        checks++; if (conflict_cnt_o !== 16'h0) begin failures++; $display("FAIL rst_async_cnt actual=%04h required=0000", conflict_cnt_o); end
        step();
        rst_n = 1'b1;
        step();
        // prio back at port 0 after reset
        set_p0(1, 0, 12'h000, '0, '0);
        set_p1(1, 0, 12'h040, '0, '0);
        @(negedge clk);
        checks++; if ({p1_gnt_o, p0_gnt_o} !== 2'b01) begin failures++; $display("FAIL rst_prio_gnt actual=%b required=01", {p1_gnt_o, p0_gnt_o}); end
        step();
        set_p0(0, 0, '0, '0, '0);
        step();
        set_p1(0, 0, '0, '0, '0);
        checks++; if (p1_rvalid_o !== 1'b1 || p1_rdata_o !== 32'hCAFEF00D) begin failures++; $display("FAIL rst_mem_kept actual=%b/%08h required=1/cafef00d", p1_rvalid_o, p1_rdata_o); end
    endtask

    task automatic test_saturation();
        checks++; if (conflict_cnt_o !== 16'd1) begin failures++; $display("FAIL sat_start actual=%0d required=1", conflict_cnt_o); end
        set_p0(1, 0, 12'h000, '0, '0);
        set_p1(1, 0, 12'h010, '0, '0);
        repeat (65000) @(posedge clk);
        #1;
        checks++; if (conflict_cnt_o !== 16'd65001) begin failures++; $display("FAIL sat_mid actual=%0d required=65001", conflict_cnt_o); end
        repeat (600) @(posedge clk);
        #1;
        checks++; if (conflict_cnt_o !== 16'hFFFF) begin failures++; $display("FAIL sat_top actual=%04h required=ffff", conflict_cnt_o); end
        @(negedge clk);
        checks++; if ((p0_gnt_o ^ p1_gnt_o) !== 1'b1) begin failures++; $display("FAIL sat_gnt_onehot actual=%b required=one-hot", {p1_gnt_o, p0_gnt_o}); end
        step();
        set_p0(0, 0, '0, '0, '0);
        set_p1(0, 0, '0, '0, '0);
        checks++; if (conflict_cnt_o !== 16'hFFFF) begin failures++; $display("FAIL sat_hold actual=%04h required=ffff", conflict_cnt_o); end
    endtask

    initial begin
        test_reset();
        test_no_conflict();
        test_byte_en();
        test_conflict_rr();
        test_rbw();
        test_back_to_back();
        test_reset_midop();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
